// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : Mode constants, request-FSM state type and totals helper for
//               the VGA raster timing generator.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    // 640x480@60
    localparam int c_480p_h_active = 640;
    localparam int c_480p_h_fp     = 16;
    localparam int c_480p_h_sync   = 96;
    localparam int c_480p_h_bp     = 48;
    localparam int c_480p_v_active = 480;
    localparam int c_480p_v_fp     = 10;
    localparam int c_480p_v_sync   = 2;
    localparam int c_480p_v_bp     = 33;
    localparam bit c_480p_sync_pol = 1'b0;

    // 1280x720@60
    localparam int c_720p_h_active = 1280;
    localparam int c_720p_h_fp     = 110;
    localparam int c_720p_h_sync   = 40;
    localparam int c_720p_h_bp     = 220;
    localparam int c_720p_v_active = 720;
    localparam int c_720p_v_fp     = 5;
    localparam int c_720p_v_sync   = 5;
    localparam int c_720p_v_bp     = 20;
    localparam bit c_720p_sync_pol = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } req_state_t;

    function automatic int mode_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_line_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : line_req_ctrl
// Description : Per-line prefetch request FSM with ack handshake, frame-wide
//               VRAM page latch and underrun detection.
// Revision    : 1.0 - initial release
// ============================================================================
module line_req_ctrl
    import vga_timing_pkg::*;
#(
    parameter int CW       = 12,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [CW-1:0] h,
    input  logic [CW-1:0] v,
    input  logic          line_ack,
    input  logic [1:0]    in_vram_no,
    output logic          line_req,
    output logic [CW-1:0] line_no,
    output logic [1:0]    vram_no,
    output logic          underrun
);

    req_state_t    r_state;
    req_state_t    w_state_nxt;
    logic [CW-1:0] r_line_no;
    logic [CW-1:0] w_line_no_nxt;
    logic [1:0]    r_vram_no;
    logic [1:0]    w_vram_no_nxt;
    logic          r_underrun;
    logic          w_underrun_nxt;
    logic [CW-1:0] w_next_line;

    assign w_next_line = (int'(v) == V_TOTAL - 1) ? '0 : v + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_line_no  <= '0;
            r_vram_no  <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_line_no  <= w_line_no_nxt;
            r_vram_no  <= w_vram_no_nxt;
            r_underrun <= w_underrun_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_line_no_nxt  = r_line_no;
        w_vram_no_nxt  = r_vram_no;
        w_underrun_nxt = 1'b0;
        if (!en) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (int'(h) == H_ACTIVE && int'(w_next_line) < V_ACTIVE) begin
                        w_state_nxt   = ST_REQ;
                        w_line_no_nxt = w_next_line;
                        // The page is frozen with the line-0 request so a whole frame shares it.
                        if (w_next_line == '0) begin
                            w_vram_no_nxt = in_vram_no;
                        end
                    end
                end
                ST_REQ: begin
                    if (line_ack) begin
                        w_state_nxt = ST_IDLE;
                    end else if (h == '0) begin
                        w_state_nxt    = ST_IDLE;
                        w_underrun_nxt = 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign line_req = (r_state == ST_REQ);
    assign line_no  = r_line_no;
    assign vram_no  = r_vram_no;
    assign underrun = r_underrun;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Parametrised raster timing generator: syncs, data enable,
//               pixel coordinates and per-line prefetch requests.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = c_480p_h_active,
    parameter int H_FP     = c_480p_h_fp,
    parameter int H_SYNC   = c_480p_h_sync,
    parameter int H_BP     = c_480p_h_bp,
    parameter int V_ACTIVE = c_480p_v_active,
    parameter int V_FP     = c_480p_v_fp,
    parameter int V_SYNC   = c_480p_v_sync,
    parameter int V_BP     = c_480p_v_bp,
    parameter bit SYNC_POL = c_480p_sync_pol,
    parameter int CW       = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [1:0]    in_vram_no,
    input  logic          line_ack,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_req,
    output logic [CW-1:0] line_no,
    output logic [1:0]    vram_no,
    output logic          frame_start,
    output logic          underrun
);

    localparam int c_h_total = mode_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int c_v_total = mode_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam logic [CW-1:0] c_v_park = CW'(c_v_total - 1);

    logic [CW-1:0] r_h;
    logic [CW-1:0] r_v;
    logic          w_h_act;
    logic          w_v_act;
    logic          w_hs_act;
    logic          w_vs_act;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_de;
    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic          r_frame_start;

    // Parking on the last line lets the line-0 request lead the first frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_h <= '0;
            r_v <= c_v_park;
        end else if (!en) begin
            r_h <= '0;
            r_v <= c_v_park;
        end else if (int'(r_h) == c_h_total - 1) begin
            r_h <= '0;
            r_v <= (int'(r_v) == c_v_total - 1) ? '0 : r_v + 1'b1;
        end else begin
            r_h <= r_h + 1'b1;
        end
    end

    assign w_h_act  = int'(r_h) < H_ACTIVE;
    assign w_v_act  = int'(r_v) < V_ACTIVE;
    assign w_hs_act = (int'(r_h) >= H_ACTIVE + H_FP) && (int'(r_h) < H_ACTIVE + H_FP + H_SYNC);
    assign w_vs_act = (int'(r_v) >= V_ACTIVE + V_FP) && (int'(r_v) < V_ACTIVE + V_FP + V_SYNC);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_de          <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_frame_start <= 1'b0;
        end else if (!en) begin
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_de          <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_hsync       <= w_hs_act ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= w_vs_act ? SYNC_POL : ~SYNC_POL;
            r_de          <= w_h_act && w_v_act;
            r_frame_start <= (r_h == '0) && (r_v == '0);
            if (w_h_act && w_v_act) begin
                r_x <= r_h;
                r_y <= r_v;
            end
        end
    end

    line_req_ctrl #(
        .CW       (CW),
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .V_TOTAL  (c_v_total)
    ) u_line_req_ctrl (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .h          (r_h),
        .v          (r_v),
        .line_ack   (line_ack),
        .in_vram_no (in_vram_no),
        .line_req   (line_req),
        .line_no    (line_no),
        .vram_no    (vram_no),
        .underrun   (underrun)
    );

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign x           = r_x;
    assign y           = r_y;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Scoreboard bench for vga_timing_gen in a small 14x7 mode.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    localparam int HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int CW = 4;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic          line_ack = 1'b0;
    logic [1:0]    in_vram_no = 2'd0;
    logic          hsync, vsync, de, line_req, frame_start, underrun;
    logic [CW-1:0] x, y, line_no;
    logic [1:0]    vram_no;

    vga_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SYNC_POL (1'b0), .CW (CW)
    ) dut (
        .clk (clk), .reset (reset), .en (en), .in_vram_no (in_vram_no),
        .line_ack (line_ack), .hsync (hsync), .vsync (vsync), .de (de),
        .x (x), .y (y), .line_req (line_req), .line_no (line_no),
        .vram_no (vram_no), .frame_start (frame_start), .underrun (underrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          hs;
        logic          vs;
        logic          de;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          req;
        logic [CW-1:0] ln;
        logic [1:0]    vr;
        logic          fs;
        logic          ur;
    } out_t;

    out_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: linear raster position within a frame plus request bookkeeping
    int   m_p;
    logic m_req;
    int   m_age;
    out_t m_o;
    int   ack_mode = 0;

    int   req_log[$];
    int   ur_cnt = 0;
    int   ur_x = -1;
    int   ur_y = -1;
    logic prev_req = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic e, input logic ack, input logic [1:0] vin);
        int h, v, n;
        if (r) begin
            m_o    = '0;
            m_o.hs = 1'b1;
            m_o.vs = 1'b1;
            m_p    = (VT - 1) * HT;
            m_req  = 1'b0;
        end else if (!e) begin
            m_o.de = 1'b0;
            m_o.hs = 1'b1;
            m_o.vs = 1'b1;
            m_o.fs = 1'b0;
            m_o.ur = 1'b0;
            m_req  = 1'b0;
            m_p    = (VT - 1) * HT;
        end else begin
            h      = m_p % HT;
            v      = m_p / HT;
            m_o.de = (h < HA) && (v < VA);
            if (m_o.de) begin
                m_o.x = CW'(h);
                m_o.y = CW'(v);
            end
            m_o.hs = !((h >= HA + HF) && (h < HA + HF + HS));
            m_o.vs = !((v >= VA + VF) && (v < VA + VF + VS));
            m_o.fs = (m_p == 0);
            m_o.ur = 1'b0;
            if (m_req) begin
                if (ack) begin
                    m_req = 1'b0;
                end else if (h == 0) begin
                    m_req  = 1'b0;
                    m_o.ur = 1'b1;
                end
            end else if (h == HA) begin
                n = (v + 1) % VT;
                if (n < VA) begin
                    m_req  = 1'b1;
                    m_o.ln = CW'(n);
                    if (n == 0) m_o.vr = vin;
                end
            end
            m_p = (m_p + 1) % FR;
        end
        m_age  = m_req ? m_age + 1 : 0;
        m_o.req = m_req;
        exp_q.push_back(m_o);
    endtask

    task automatic step(input logic r, input logic e);
        @(negedge clk);
        reset = r;
        en    = e;
        case (ack_mode)
            0:       line_ack = 1'b1;
            1:       line_ack = m_req && (m_age >= 4);
            2:       line_ack = m_req && (m_age >= 4) && (int'(m_o.ln) != 2);
            default: line_ack = ($urandom_range(0, 3) == 0);
        endcase
        model_step(r, e, line_ack, in_vram_no);
    endtask

    // Monitor: one expected record per output cycle
    initial begin
        out_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("hsync", int'(hsync), int'(e.hs));
                chk("vsync", int'(vsync), int'(e.vs));
                chk("de", int'(de), int'(e.de));
                chk("x", int'(x), int'(e.x));
                chk("y", int'(y), int'(e.y));
                chk("line_req", int'(line_req), int'(e.req));
                chk("line_no", int'(line_no), int'(e.ln));
                chk("vram_no", int'(vram_no), int'(e.vr));
                chk("frame_start", int'(frame_start), int'(e.fs));
                chk("underrun", int'(underrun), int'(e.ur));
                if (line_req && !prev_req) req_log.push_back(int'(line_no));
                prev_req = line_req;
                if (underrun) begin
                    ur_cnt++;
                    ur_x = int'(x);
                    ur_y = int'(y);
                end
            end
        end
    end

    task automatic drain();
        @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int idx;
        bit seen;
        repeat (3) step(1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0);

        // Ack tied high
        ack_mode = 0;
        repeat (2 * FR + 10) step(1'b0, 1'b1);

        // Ack three cycles after each request rises
        drain();
        req_log.delete();
        ur_cnt   = 0;
        ack_mode = 1;
        repeat (2 * FR) step(1'b0, 1'b1);
        drain();
        chk("ph2_underruns", ur_cnt, 0);
        chk("ph2_req_count", req_log.size(), 2 * VA);
        foreach (req_log[i]) chk("ph2_line_order", req_log[i], (req_log[0] + i) % VA);

        // Line 2 starved
        req_log.delete();
        ur_cnt   = 0;
        ack_mode = 2;
        repeat (FR) step(1'b0, 1'b1);
        drain();
        chk("ph3_underrun_count", ur_cnt, 1);
        chk("ph3_underrun_x", ur_x, 0);
        chk("ph3_underrun_y", ur_y, 2);
        idx = -1;
        foreach (req_log[i]) if (req_log[i] == 2 && idx < 0) idx = i;
        chk("ph3_line2_requested", int'(idx >= 0), 1);
        if (idx >= 0 && idx + 1 < req_log.size()) chk("ph3_line3_follows", req_log[idx + 1], 3);

        // Page change mid-frame
        ack_mode   = 0;
        in_vram_no = 2'd2;
        repeat (FR + 20) step(1'b0, 1'b1);
        drain();
        chk("ph4_vram_no", int'(vram_no), 2);

        // Random ack, page and enable
        ack_mode = 3;
        repeat (400) begin
            if ($urandom_range(0, 29) == 0) in_vram_no = 2'($urandom_range(0, 3));
            step(1'b0, $urandom_range(0, 39) != 0);
        end

        // Reset while a request is outstanding
        ack_mode = 1;
        seen = 1'b0;
        for (int i = 0; i < 3 * FR && !seen; i++) begin
            if (m_req) seen = 1'b1;
            else step(1'b0, 1'b1);
        end
        chk("ph6_req_seen", int'(seen), 1);
        step(1'b1, 1'b1);
        #1;
        chk("async_reset_line_req", int'(line_req), 0);
        chk("async_reset_hsync", int'(hsync), 1);
        chk("async_reset_de", int'(de), 0);
        chk("async_reset_vram_no", int'(vram_no), 0);
        step(1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b0);
        drain();
        req_log.delete();
        repeat (FR + 30) step(1'b0, 1'b1);
        drain();
        chk("ph6_first_req_line", (req_log.size() > 0) ? req_log[0] : -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised raster timing generator for the VGA output path. It produces hsync, vsync, data-enable and pixel coordinates for any mode set by parameters; 640x480@60 is the default. It also issues per-line prefetch requests, with an ack handshake, to the DDR line-fetch logic. It latches the VRAM page once per frame and flags lines whose data did not arrive in time.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch / sync / porch in lines
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)
- CW, 12, counter and coordinate width; H_TOTAL and V_TOTAL must each be ≤ 2^CW
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- en  in  1  run enable; low parks the raster
- in_vram_no  in  2  requested VRAM page
- line_ack  in  1  fetch logic accepted the current line_req
- hsync / vsync  out  1  sync outputs, polarity per SYNC_POL
- de  out  1  active-video enable
- x / y  out  CW  pixel coordinates; valid while de=1
- line_req  out  1  line prefetch request, level, held until acked
- line_no  out  CW  line being requested; stable while line_req=1
- vram_no  out  2  page in use for the current frame
- frame_start  out  1  one-cycle pulse with pixel (0,0)
- underrun  out  1  one-cycle pulse: a request was still unacked when its line started

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Counters: h counts 0..H_TOTAL-1 and wraps, incrementing v; v counts 0..V_TOTAL-1 and wraps.
- Active region: de=1 iff h<H_ACTIVE and v<V_ACTIVE; then x=h and y=v. Outside it x and y hold their last values.
- hsync is active iff H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC.
- vsync is active iff V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC, for the whole line, changing at h=0.
- Request FSM states: IDLE, REQ.
  - IDLE→REQ at h=H_ACTIVE on line v, if n=(v+1) mod V_TOTAL < V_ACTIVE. line_no=n.
  - REQ→IDLE on line_ack=1. A line_ack in the same cycle line_req rises counts as accepted.
  - REQ→IDLE when h wraps to 0 on line n without an ack: underrun pulses, the request is dropped, and the next request is issued normally.
- line_ack while in IDLE is ignored.
- vram_no samples in_vram_no only in the cycle the line-0 request is issued (h=H_ACTIVE, v=V_TOTAL-1). All requests and pixels of that frame share the value. A mid-frame in_vram_no change takes effect next frame.
- en=0:
  - h=0, v=V_TOTAL-1; counters hold.
  - de=0, syncs inactive, FSM forced to IDLE, line_req=0.
  - vram_no holds.
  - On en rising the raster starts at the last line, so the line-0 request precedes the first frame_start.
- en falling mid-request: the request is dropped, with no underrun.

## Timing
- All outputs registered. hsync, vsync, de, x, y, frame_start, line_req, line_no and underrun are mutually aligned, one cycle after the counter state they decode.
- Reset values: hsync=vsync=~SYNC_POL, de=0, x=y=0, line_req=0, line_no=0, vram_no=0, frame_start=0, underrun=0. Counters reset to h=0, v=V_TOTAL-1.
- line_req rises in the same output cycle de falls at the end of a line; it falls the output cycle after the accepting line_ack.
- underrun is output-aligned with the first de=1 cycle of the starved line.
- Reset asserted mid-frame: all state returns to reset values immediately. An outstanding request is abandoned without underrun.

## Structure
- Shared package vga_timing_pkg holds:
  - mode constant sets (480p default, 720p: 1280/110/40/220, 720/5/5/20, SYNC_POL=1);
  - the request-FSM state enum;
  - a function computing totals.
- Sub-module line_req_ctrl: the request FSM, line_no, vram_no latch and underrun, driven by the h/v counters.

## Test plan
- Small mode (H 8/2/2/2, V 4/1/1/1), en=1, ack tied high:
  - de high for 8 of 14 cycles per line;
  - hsync active at h=10..11;
  - vsync active on line 5;
  - frame_start every 98 cycles.
- Default 480p: each frame has 480 de lines of 640 pixels and 525 lines of 800 clocks; hsync low 96 clocks, vsync low 2 lines.
- Ack delayed 3 cycles after each line_req: line_no=0..V_ACTIVE-1 in order, each held until ack; no underrun.
- line_ack withheld for line 2: underrun pulses exactly once, with y=2 at x=0; the line-3 request follows at the normal time.
- in_vram_no 0→2 mid-frame: vram_no stays 0 until the line-0 request, then reads 2.
- Reset asserted while line_req=1, then en toggled low/high: all outputs return to reset values. The first event after en rises is line_req with line_no=0, before frame_start.
